cpu_core: RTL and testbench

Hack-style instruction sequencer that drives the 16-bit ALU from the other side of its operand/opcode interface. It fetches 16-bit instructions from an instruction ROM and decodes A- and C-instructions. It presents x/y/opcode to the ALU, waits a fixed ALU latency, then writes the result back to the A/D registers and/or data memory and resolves jumps. It sits between the instruction ROM, the data RAM and the `alu` block in the top-level CPU.

---
 rtl/cpu_core.sv | 173 +++++++++++++++++
 tb/tb_cpu_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// cpu_core: Hack-style instruction sequencer.
//
// Fetches 16-bit instructions from a synchronous instruction ROM, decodes
// A- and C-instructions, drives the operand/opcode side of an external ALU,
// waits ALU_LATENCY cycles, then writes back to A/D/M and resolves jumps.
//
// Ports
//   clk          clock, rising-edge
//   rst          synchronous active-high reset
//   pc           instruction ROM address (ROM data arrives next cycle)
//   instr        instruction ROM data
//   alu_x        ALU x operand (D)
//   alu_y        ALU y operand (A, or mem_rdata when the a-bit is set)
//   alu_opcode   {a, zx, nx, zy, ny, f, no}
//   alu_result   ALU output, sampled in WB
//   mem_addr     data RAM address, always A[14:0]
//   mem_rdata    data RAM read data (combinational from mem_addr)
//   mem_wdata    data RAM write data (alu_result)
//   mem_we       one-cycle RAM write strobe
//   a_reg        A register (debug)
//   d_reg        D register (debug)
//   retire       one-cycle pulse in the last cycle of each instruction
//
// state  | meaning
// FETCH  | pc presented to the ROM
// DECODE | instr valid; A-instr completes, C-instr loads ALU operands
// EXEC   | operands held stable while the ALU settles
// WB     | alu_result written back, jump resolved

module cpu_core #(
  parameter int ALU_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [14:0] pc,
  input  logic [15:0] instr,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [6:0]  alu_opcode,
  input  logic [15:0] alu_result,
  output logic [14:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [15:0] a_reg,
  output logic [15:0] d_reg,
  output logic        retire
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);

  state_t      state, state_nxt;
  logic [14:0] pc_q, pc_nxt;
  logic [15:0] a_q, a_nxt;
  logic [15:0] d_q, d_nxt;
  // Only the destination and jump fields are needed after DECODE.
  logic [5:0]  ir_q, ir_nxt;
  logic [15:0] x_q, x_nxt;
  logic [15:0] y_q, y_nxt;
  logic [6:0]  op_q, op_nxt;
  logic [3:0]  cnt_q, cnt_nxt;
  logic        retire_c;
  logic        we_c;
  logic        zr, ng, take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc_q  <= '0;
      a_q   <= '0;
      d_q   <= '0;
      ir_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      a_q   <= a_nxt;
      d_q   <= d_nxt;
      ir_q  <= ir_nxt;
      x_q   <= x_nxt;
      y_q   <= y_nxt;
      op_q  <= op_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign zr   = (alu_result == 16'h0000);
  assign ng   = alu_result[15];
  assign take = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    a_nxt     = a_q;
    d_nxt     = d_q;
    ir_nxt    = ir_q;
    x_nxt     = x_q;
    y_nxt     = y_q;
    op_nxt    = op_q;
    cnt_nxt   = cnt_q;
    retire_c  = 1'b0;
    we_c      = 1'b0;

    case (state)
      FETCH: begin
        state_nxt = DECODE;
      end

      DECODE: begin
        ir_nxt = instr[5:0];
        if (!instr[15]) begin
          a_nxt     = {1'b0, instr[14:0]};
          pc_nxt    = pc_q + 15'd1;
          retire_c  = 1'b1;
          state_nxt = FETCH;
        end else begin
          // y mux uses the A value current at DECODE; M is read through it.
          x_nxt     = d_q;
          y_nxt     = instr[12] ? mem_rdata : a_q;
          op_nxt    = instr[12:6];
          cnt_nxt   = LAT_M1;
          state_nxt = EXEC;
        end
      end

      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_nxt = WB;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end

      WB: begin
        retire_c = 1'b1;
        // a_q is still the pre-writeback A here, so the jump target and
        // mem_addr both see the old value even when d1 is set.
        if (ir_q[5]) a_nxt = alu_result;
        if (ir_q[4]) d_nxt = alu_result;
        we_c      = ir_q[3];
        pc_nxt    = take ? a_q[14:0] : pc_q + 15'd1;
        state_nxt = FETCH;
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  assign pc         = pc_q;
  assign alu_x      = x_q;
  assign alu_y      = y_q;
  assign alu_opcode = op_q;
  assign mem_addr   = a_q[14:0];
  assign mem_wdata  = alu_result;
  // Gated so a reset landing on WB can never produce a stray write.
  assign mem_we     = we_c & ~rst;
  assign retire     = retire_c & ~rst;
  assign a_reg      = a_q;
  assign d_reg      = d_q;

endmodule

// File: tb/tb_cpu_core.sv
module tb_cpu_core;

  logic        clk;
  logic        rst;
  logic [14:0] pc;
  logic [15:0] instr;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [6:0]  alu_opcode;
  logic [15:0] alu_result;
  logic [14:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic        retire;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [0:32767];
  logic [15:0] ram [0:32767];
  logic [15:0] p1, p2;

  cpu_core #(.ALU_LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instr      (instr),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .a_reg      (a_reg),
    .d_reg      (d_reg),
    .retire     (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM.
  always @(posedge clk) instr <= rom[pc];

  // RAM: combinational read, write on clock edge.
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [6:0] op);
    logic [15:0] xx, yy, o;
    xx = x;
    yy = y;
    if (op[5]) xx = 16'h0000;
    if (op[4]) xx = ~xx;
    if (op[3]) yy = 16'h0000;
    if (op[2]) yy = ~yy;
    o = op[1] ? (xx + yy) : (xx & yy);
    if (op[0]) o = ~o;
    return o;
  endfunction

  // Two-stage ALU model: result is only correct ALU_LATENCY=2 cycles after
  // the operands settle, so an early WB samples a stale value.
  always @(posedge clk) begin
    p1 <= hack_alu(alu_x, alu_y, alu_opcode);
    p2 <= p1;
  end
  assign alu_result = p2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_prog(input int p);
    for (int i = 0; i < 32768; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'h0000;
    end
    ram[16] = 16'h1234;
    case (p)
      1: begin rom[0] = 16'h0005; rom[1] = 16'hEC10; end
      2: begin rom[0] = 16'h0006; rom[1] = 16'hEC10; rom[2] = 16'h0010; rom[3] = 16'hE7C8; end
      3: begin rom[0] = 16'h0020; rom[1] = 16'hE302; end
      4: begin rom[0] = 16'h0001; rom[1] = 16'hEC10; rom[2] = 16'h0020; rom[3] = 16'hE302; end
      5: begin rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[32767] = 16'h0003; end
      6: begin rom[0] = 16'h0010; rom[1] = 16'hFC10; end
      default: ;
    endcase
  endtask

  // Holds reset for n edges; returns just inside cycle 1 (first FETCH).
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_to(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  typedef struct {
    int          prog;
    int          cyc;
    logic [14:0] pc;
    logic [15:0] a;
    logic [15:0] d;
    logic        ret;
    logic        we;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int pulses;
    logic prev_we;
    logic [14:0] we_addr;
    logic [15:0] we_data;

    rst = 1'b1;

    vecs.push_back('{1,  1, 15'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1,  2, 15'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1,  3, 15'h0001, 16'h0005, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1,  5, 15'h0001, 16'h0005, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1,  6, 15'h0001, 16'h0005, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1,  7, 15'h0001, 16'h0005, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1,  8, 15'h0002, 16'h0005, 16'h0005, 1'b0, 1'b0});
    vecs.push_back('{2,  9, 15'h0002, 16'h0006, 16'h0006, 1'b1, 1'b0});
    vecs.push_back('{2, 14, 15'h0003, 16'h0010, 16'h0006, 1'b1, 1'b1});
    vecs.push_back('{2, 15, 15'h0004, 16'h0010, 16'h0006, 1'b0, 1'b0});
    vecs.push_back('{3,  7, 15'h0001, 16'h0020, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{3,  8, 15'h0020, 16'h0020, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{4, 14, 15'h0003, 16'h0020, 16'h0001, 1'b1, 1'b0});
    vecs.push_back('{4, 15, 15'h0004, 16'h0020, 16'h0001, 1'b0, 1'b0});
    vecs.push_back('{5,  8, 15'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{5,  9, 15'h7FFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{5, 10, 15'h0000, 16'h0003, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{6,  8, 15'h0002, 16'h0010, 16'h1234, 1'b0, 1'b0});

    foreach (vecs[k]) begin
      load_prog(vecs[k].prog);
      do_reset(2);
      run_to(vecs[k].cyc);
      chk($sformatf("p%0d c%0d pc", vecs[k].prog, vecs[k].cyc), 32'(pc), 32'(vecs[k].pc));
      chk($sformatf("p%0d c%0d a_reg", vecs[k].prog, vecs[k].cyc), 32'(a_reg), 32'(vecs[k].a));
      chk($sformatf("p%0d c%0d d_reg", vecs[k].prog, vecs[k].cyc), 32'(d_reg), 32'(vecs[k].d));
      chk($sformatf("p%0d c%0d retire", vecs[k].prog, vecs[k].cyc), 32'(retire), 32'(vecs[k].ret));
      chk($sformatf("p%0d c%0d mem_we", vecs[k].prog, vecs[k].cyc), 32'(mem_we), 32'(vecs[k].we));
    end

    // Operands held stable through EXEC for D=A after @5.
    load_prog(1);
    do_reset(2);
    run_to(5);
    chk("exec1 alu_opcode", 32'(alu_opcode), 32'(7'b0110000));
    chk("exec1 alu_y", 32'(alu_y), 32'h0005);
    chk("exec1 alu_x", 32'(alu_x), 32'h0000);
    run_to(1);
    chk("exec2 alu_opcode", 32'(alu_opcode), 32'(7'b0110000));
    chk("exec2 alu_y", 32'(alu_y), 32'h0005);

    // M=D+1 program: exactly one write strobe, never back-to-back.
    load_prog(2);
    do_reset(2);
    pulses  = 0;
    prev_we = 1'b0;
    we_addr = '0;
    we_data = '0;
    for (int c = 1; c <= 20; c++) begin
      run_to(1);
      if (mem_we) begin
        pulses++;
        we_addr = mem_addr;
        we_data = mem_wdata;
        chk("mem_we not consecutive", 32'(prev_we), 32'h0);
      end
      prev_we = mem_we;
    end
    chk("mem_we pulse count", 32'(pulses), 32'd1);
    chk("mem_we addr", 32'(we_addr), 32'h0010);
    chk("mem_we data", 32'(we_data), 32'h0007);
    chk("ram[16] after M=D+1", 32'(ram[16]), 32'h0007);
    chk("d_reg after M=D+1", 32'(d_reg), 32'h0006);

    // Reset held 4 cycles mid-program.
    load_prog(2);
    do_reset(2);
    run_to(12);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    run_to(1);
    chk("midrst pc", 32'(pc), 32'h0);
    chk("midrst a_reg", 32'(a_reg), 32'h0);
    chk("midrst d_reg", 32'(d_reg), 32'h0);
    chk("midrst mem_we", 32'(mem_we), 32'h0);
    chk("midrst retire", 32'(retire), 32'h0);

    // Reset landing on the WB cycle of M=D+1.
    load_prog(2);
    do_reset(2);
    run_to(14);
    chk("wbrst pre retire", 32'(retire), 32'h1);
    rst = 1'b1;
    #1;
    chk("wbrst mem_we gated", 32'(mem_we), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_to(1);
    chk("wbrst pc", 32'(pc), 32'h0);
    chk("wbrst mem_we after", 32'(mem_we), 32'h0);
    chk("wbrst ram untouched", 32'(ram[16]), 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
